// File: rtl/timer_dev.sv
// Programmable down-counting timer on the data-memory load/store path.
// One-shot and auto-reload modes with a maskable interrupt request.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t              state,     state_nxt;
    logic                ctrl_en,   ctrl_en_nxt;
    logic [1:0]          ctrl_mode, ctrl_mode_nxt;
    logic                ctrl_im,   ctrl_im_nxt;
    logic [DATA_W-1:0]   preset,    preset_nxt;
    logic [DATA_W-1:0]   count,     count_nxt;
    logic                irq_flag,  irq_flag_nxt;

    // State and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            irq_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctrl_en   <= ctrl_en_nxt;
            ctrl_mode <= ctrl_mode_nxt;
            ctrl_im   <= ctrl_im_nxt;
            preset    <= preset_nxt;
            count     <= count_nxt;
            irq_flag  <= irq_flag_nxt;
        end
    end

    // Next-state: FSM first, then bus writes override (a CTRL write beats the one-shot EN clear)
    always_comb begin
        state_nxt     = state;
        ctrl_en_nxt   = ctrl_en;
        ctrl_mode_nxt = ctrl_mode;
        ctrl_im_nxt   = ctrl_im;
        preset_nxt    = preset;
        count_nxt     = count;
        irq_flag_nxt  = irq_flag;

        case (state)
            IDLE: begin
                if (ctrl_en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!ctrl_en) begin
                    state_nxt = IDLE;
                end else begin
                    count_nxt = preset;
                    state_nxt = CNT;
                end
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_nxt = IDLE;
                end else if (count > DATA_W'(1)) begin
                    count_nxt = count - DATA_W'(1);
                end else begin
                    count_nxt    = '0;
                    irq_flag_nxt = 1'b1;
                    state_nxt    = INT;
                end
            end
            INT: begin
                if (ctrl_mode == MODE_RELOAD) begin
                    irq_flag_nxt = 1'b0;
                end else begin
                    ctrl_en_nxt = 1'b0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (we) begin
            case (addr)
                ADDR_CTRL: begin
                    ctrl_en_nxt   = wdata[0];
                    ctrl_mode_nxt = wdata[2:1];
                    ctrl_im_nxt   = wdata[3];
                    irq_flag_nxt  = 1'b0;
                end
                ADDR_PRESET: begin
                    preset_nxt   = wdata;
                    irq_flag_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read mux; COUNT and the reserved slot ignore writes
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = DATA_W'({ctrl_im, ctrl_mode, ctrl_en});
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = '0;
        endcase
    end

    assign irq = ctrl_im & irq_flag;

    logic unused_ok;
    assign unused_ok = &{1'b0, CTRL_W[0]};

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus queues expected rdata/irq per cycle,
// a negedge monitor pops and compares.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has come
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (rdata !== e.rd) begin
                n_fail++;
                $display("FAIL %s rdata: got %h expected %h (cycle %0d)", e.name, rdata, e.rd, cyc);
            end
            n_cmp++;
            if (irq !== e.irq) begin
                n_fail++;
                $display("FAIL %s irq: got %b expected %b (cycle %0d)", e.name, irq, e.irq, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic chk(input string n, input logic [1:0] a, input logic [31:0] rd, input logic ir);
        exp_t e;
        addr   = a;
        e.cyc  = cyc;
        e.rd   = rd;
        e.irq  = ir;
        e.name = n;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_ctrl",   2'd0, 32'd0, 1'b0); tick();
        chk("rst_preset", 2'd1, 32'd0, 1'b0); tick();
        chk("rst_count",  2'd2, 32'd0, 1'b0); tick();
        chk("rst_rsvd",   2'd3, 32'd0, 1'b0); tick();

        // One-shot, P = 5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(); tick();
        for (int k = 0; k <= 5; k++) begin
            chk("oneshot_count", 2'd2, 32'(5 - k), (k == 5));
            tick();
        end
        chk("oneshot_ctrl", 2'd0, 32'h8, 1'b1); tick();
        chk("oneshot_hold", 2'd0, 32'h8, 1'b1); tick();
        wr(2'd0, 32'h8);
        chk("oneshot_clear", 2'd0, 32'h8, 1'b0); tick();

        // Auto-reload, P = 3: period 6
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        tick(); tick();
        for (int n = 2; n <= 19; n++) begin
            int m;
            m = (n - 2) % 6;
            chk("reload", 2'd2, (m < 3) ? 32'(3 - m) : 32'd0, (m == 3));
            tick();
        end
        wr(2'd0, 32'h0);
        chk("reload_stop", 2'd0, 32'h0, 1'b0); tick();
        tick();

        // Masked interrupt
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        tick(); tick();
        chk("mask_c2", 2'd2, 32'd2, 1'b0); tick();
        chk("mask_c1", 2'd2, 32'd1, 1'b0); tick();
        chk("mask_c0", 2'd2, 32'd0, 1'b0); tick();
        chk("mask_ctrl", 2'd0, 32'h0, 1'b0); tick();
        wr(2'd0, 32'h8);
        chk("mask_im_on", 2'd0, 32'h8, 1'b0); tick();
        chk("mask_im_hold", 2'd0, 32'h8, 1'b0); tick();

        // Stop and preset change while counting
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        repeat (12) tick();
        chk("stop_c10", 2'd2, 32'd10, 1'b0); tick();
        wr(2'd1, 32'd4);
        chk("stop_preset_c8", 2'd2, 32'd8, 1'b0); tick();
        chk("stop_c7", 2'd2, 32'd7, 1'b0); tick();
        wr(2'd0, 32'h0);
        chk("stop_c5", 2'd2, 32'd5, 1'b0); tick();
        chk("stop_frz1", 2'd2, 32'd5, 1'b0); tick();
        chk("stop_frz2", 2'd2, 32'd5, 1'b0); tick();
        wr(2'd0, 32'h1);
        chk("reen_idle", 2'd2, 32'd5, 1'b0); tick();
        chk("reen_load", 2'd2, 32'd5, 1'b0); tick();
        chk("reen_c4",   2'd2, 32'd4, 1'b0); tick();
        wr(2'd0, 32'h0);
        chk("reen_stop",  2'd2, 32'd2, 1'b0); tick();
        chk("reen_frz",   2'd2, 32'd2, 1'b0); tick();

        // Bus edges
        wr(2'd2, 32'hDEAD_BEEF);
        chk("count_ro", 2'd2, 32'd2, 1'b0); tick();
        wr(2'd3, 32'h1234_5678);
        chk("rsvd_ro", 2'd3, 32'd0, 1'b0); tick();
        chk("rsvd_preset", 2'd1, 32'd4, 1'b0); tick();
        wr(2'd0, 32'hFFFF_FFF8);
        chk("ctrl_hi_zero", 2'd0, 32'h8, 1'b0); tick();

        // PRESET = 0: irq three cycles after EN
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        chk("p0_e0", 2'd0, 32'h9, 1'b0); tick();
        chk("p0_e1", 2'd0, 32'h9, 1'b0); tick();
        chk("p0_e2", 2'd2, 32'd0, 1'b0); tick();
        chk("p0_e3", 2'd0, 32'h9, 1'b1); tick();
        chk("p0_e4", 2'd0, 32'h8, 1'b1); tick();

        // Reset mid-count at COUNT = 7
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        repeat (5) tick();
        chk("mid_c7", 2'd2, 32'd7, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ctrl",   2'd0, 32'd0, 1'b0); tick();
        chk("mid_rst_preset", 2'd1, 32'd0, 1'b0); tick();
        chk("mid_rst_count",  2'd2, 32'd0, 1'b0); tick();

        tick(); tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
